// File: rtl/prime_word_serializer.sv
// Parallel-to-serial front end for the serial prime detector.
// Words go out MSB-first with framing strobes and a one-word holding buffer.
module prime_word_serializer #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             in_bit,
   output logic             bit_valid,
   output logic             word_first,
   output logic             word_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [3:0] GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [3:0]       gcnt_q, gcnt_d;

   logic accept;
   logic launch;
   logic direct;

   assign in_ready   = rst && !hold_full_q;
   assign accept     = in_valid && in_ready;

   assign bit_valid  = (state_q == S_SHIFT);
   assign in_bit     = bit_valid ? sreg_q[WIDTH-1] : 1'b0;
   assign word_first = bit_valid && (cnt_q == '0);
   assign word_last  = bit_valid && (cnt_q == LAST);
   assign busy       = (state_q != S_IDLE) || hold_full_q;

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      gcnt_d      = gcnt_q;
      launch      = 1'b0;
      direct      = 1'b0;

      unique case (state_q)
         S_IDLE: launch = 1'b1;
         S_SHIFT: begin
            if (out_ready) begin
               if (cnt_q != LAST) begin
                  sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                  cnt_d  = cnt_q + 1'b1;
               end else if (GAP > 0) begin
                  state_d = S_GAP;
                  gcnt_d  = GAP_INIT;
               end else begin
                  launch = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gcnt_q == 4'd0) launch = 1'b1;
            else gcnt_d = gcnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase

      // Start of a new word: a buffered word always wins over the input.
      if (launch) begin
         if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_SHIFT;
         end else if (accept) begin
            sreg_d  = data_in;
            cnt_d   = '0;
            state_d = S_SHIFT;
            direct  = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end

      if (accept && !direct) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         gcnt_q      <= 4'd0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         gcnt_q      <= gcnt_d;
      end
   end

endmodule

// File: doc/prime_word_serializer.md
Name: prime_word_serializer

Overview:
- Parallel-to-serial front end for the serial prime detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per accepted cycle, on a single serial line (in_bit) that drives the detector's in_bit input.
- Provides framing strobes (word_first, word_last) so downstream logic can align the detector's prime output with word boundaries.
- Contains a one-word holding buffer so back-to-back words stream with no bubble.

Parameters:
- WIDTH, 4, bits per word; legal range 2..16.
- GAP, 0, idle cycles inserted between consecutive words; legal range 0..15. During these cycles bit_valid=0 and in_bit=0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- data_in  input  WIDTH  parallel word to serialize; bit WIDTH-1 is sent first.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can take a word; a transfer occurs on a rising edge where in_valid && in_ready.
- out_ready  input  1  consumer takes the current bit this cycle. Tie to 1 when driving the detector directly.
- in_bit  output  1  serial data; equals shift-register MSB while bit_valid, else 0.
- bit_valid  output  1  in_bit carries a word bit.
- word_first  output  1  high while the first (MSB) bit of a word is presented.
- word_last  output  1  high while the last (LSB) bit of a word is presented.
- busy  output  1  state != IDLE or holding buffer full.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage:
  - sreg[WIDTH-1:0]: shift register.
  - cnt: bit index, width clog2(WIDTH).
  - hold[WIDTH-1:0] with flag hold_full.
  - gcnt: gap counter, 4 bits.
  - FSM states: IDLE, SHIFT, GAP.
- Reset (rst=0, asynchronous):
  - state=IDLE; sreg, cnt, hold, gcnt = 0; hold_full=0.
  - All outputs 0, including in_ready (gated by rst).
  - Reset in mid-word aborts the word; remaining bits and any held word are discarded.
- in_ready = rst && !hold_full. It is combinational from registers only, with no path from in_valid.
- Outputs are decoded from registered state only:
  - bit_valid = (state==SHIFT).
  - in_bit = bit_valid ? sreg[WIDTH-1] : 0.
  - word_first = bit_valid && cnt==0.
  - word_last = bit_valid && cnt==WIDTH-1.
- Accept routing: an accepted word loads sreg directly if, at that edge, state==IDLE, or the SHIFT→IDLE/next-word transition occurs with hold empty and GAP==0. Otherwise it loads hold and sets hold_full.
- IDLE:
  - If hold_full: sreg<=hold, hold_full<=0, cnt<=0, go to SHIFT.
  - Else on accept: sreg<=data_in, cnt<=0, go to SHIFT.
  - Latency: word accepted at edge k gives its first bit valid in the cycle after edge k.
- SHIFT:
  - If out_ready=0: sreg, cnt and outputs hold unchanged (stall).
  - If out_ready=1 and cnt<WIDTH-1: sreg<=sreg<<1, cnt<=cnt+1.
  - If out_ready=1 and cnt==WIDTH-1:
    - GAP>0: go to GAP with gcnt<=GAP-1.
    - GAP==0 and hold_full: load hold into sreg, clear hold_full, cnt<=0, stay in SHIFT (zero bubble).
    - GAP==0 and hold empty with an accept this edge: load data_in into sreg, stay in SHIFT.
    - Otherwise: go to IDLE.
- GAP:
  - Outputs idle.
  - gcnt decrements each cycle; out_ready is ignored.
  - At gcnt==0, transition as from IDLE in the same edge (load hold, or accept directly).
- Handshake rules:
  - in_valid=1 with in_ready=0 causes no transfer; the producer must hold data_in.
  - in_valid is ignored during reset.
- Simultaneous accept and hold drain at one edge cannot occur, because in_ready=0 while hold_full.
- No arithmetic overflow is possible: cnt wraps only by reload to 0.

Test Plan:
1. WIDTH=4, GAP=0, out_ready=1. Single word 4'b1011 accepted at edge 0 → in_bit=1,0,1,1 in cycles 1–4. word_first only in cycle 1, word_last only in cycle 4. Cycle 5: bit_valid=0, busy=0.
2. Back-to-back words 4'h5, 4'hD, 4'h7 with in_valid held high → 12 consecutive valid bits 0101 1101 0111 with no bubble. in_ready drops while hold is full and returns the cycle after each reload.
3. out_ready=0 for 3 cycles while the second bit of 4'b1001 is presented → in_bit=0, cnt and word_first/word_last frozen. The word completes with total valid-bit count 4.
4. GAP=2, words 4'hA then 4'h3 → bits 1010, 2 cycles with bit_valid=0 and in_bit=0, then 0011.
5. rst pulled low during cycle 2 of 4'hF with 4'h6 held → all outputs 0 immediately (asynchronous). After release: IDLE, in_ready=1, and neither the rest of 4'hF nor 4'h6 is ever emitted.
6. Driving the detector with out_ready=1: stream words 4'd7, 4'd9 and sample prime one cycle after each word_last → prime=1 after 7, prime=0 after 9.
